// File: rtl/mem_bus_responder.sv
// Single-port word-array bus responder: fixed-latency read/byte-lane write, one completion pulse per request.
// Define MEM_RESP_RANGE_CHECK_EN to flag out-of-range addresses with bus_err instead of aliasing them.
module mem_bus_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_en,
    input  logic [31:0] mem_addr,
    input  logic        mem_rd_wr,
    input  logic [1:0]  mem_wr_size,
    input  logic [31:0] bus_data_in,
    output logic [31:0] bus_data_out,
    output logic        bus_data_oe,
    output logic        mem_data_valid,
    output logic        bus_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND, RELEASE} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdat_q;
    logic        rd_wr_q;
    logic [1:0]  size_q;
    logic [31:0] rdat_q;
    logic        oe_q;
    logic        vld_q;
    logic        err_q;

    logic [31:0] mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] idx;
    logic                  range_err;
    logic [2:0]            lane_lo;
    logic [2:0]            lane_hi;
    logic [2:0]            lane_off;
    logic [3:0]            wr_mask;
    logic [31:0]           wr_word;

    assign idx = addr_q[DEPTH_LOG2+1:2];

`ifdef MEM_RESP_RANGE_CHECK_EN
    assign range_err = |addr_q[31:DEPTH_LOG2+2];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_q[31:DEPTH_LOG2+2];
    assign range_err      = 1'b0;
`endif

    // Lanes run from addr[1:0] upward; anything past lane 3 simply falls off the word.
    always_comb begin
        lane_lo  = {1'b0, addr_q[1:0]};
        lane_hi  = lane_lo + ((size_q == 2'b00) ? 3'd4 : {1'b0, size_q});
        lane_off = 3'd0;
        wr_mask  = 4'b0000;
        wr_word  = 32'h0;
        for (int j = 0; j < 4; j++) begin
            lane_off = 3'(j) - lane_lo;
            if (3'(j) >= lane_lo && 3'(j) < lane_hi) begin
                wr_mask[j]       = 1'b1;
                wr_word[j*8 +: 8] = wdat_q[{lane_off[1:0], 3'b000} +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == RESPOND && rd_wr_q && !err_q) begin
            for (int j = 0; j < 4; j++) begin
                if (wr_mask[j]) begin
                    mem_q[idx][j*8 +: 8] <= wr_word[j*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdat_q  <= 32'h0;
            rd_wr_q <= 1'b0;
            size_q  <= 2'b00;
            rdat_q  <= 32'h0;
            oe_q    <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_req && mem_en) begin
                        addr_q  <= mem_addr;
                        wdat_q  <= bus_data_in;
                        rd_wr_q <= mem_rd_wr;
                        size_q  <= mem_wr_size;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESPOND;
                        vld_q   <= 1'b1;
                        err_q   <= range_err;
                        if (!rd_wr_q) begin
                            oe_q   <= 1'b1;
                            rdat_q <= range_err ? 32'hDEADBEEF : mem_q[idx];
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESPOND: begin
                    vld_q   <= 1'b0;
                    oe_q    <= 1'b0;
                    err_q   <= 1'b0;
                    rdat_q  <= 32'h0;
                    state_q <= RELEASE;
                end
                RELEASE: begin
                    if (!mem_req) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_data_out   = rdat_q;
    assign bus_data_oe    = oe_q;
    assign mem_data_valid = vld_q;
    assign bus_err        = err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed self-checking bench for mem_bus_responder (DEPTH_LOG2=8, LATENCY=3).
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic        mem_rd_wr;
    logic [1:0]  mem_wr_size;
    logic [31:0] bus_data_in;
    logic [31:0] bus_data_out;
    logic        bus_data_oe;
    logic        mem_data_valid;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_bus_responder #(.DEPTH_LOG2(8), .LATENCY(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req        (mem_req),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_rd_wr      (mem_rd_wr),
        .mem_wr_size    (mem_wr_size),
        .bus_data_in    (bus_data_in),
        .bus_data_out   (bus_data_out),
        .bus_data_oe    (bus_data_oe),
        .mem_data_valid (mem_data_valid),
        .bus_err        (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".vld"}, 32'(mem_data_valid), 32'd0);
        check({tag, ".oe"},  32'(bus_data_oe),    32'd0);
        check({tag, ".dat"}, bus_data_out,        32'h0);
        check({tag, ".err"}, 32'(bus_err),        32'd0);
    endtask

    // Called at a falling edge with the responder idle; returns at a falling edge with it idle again.
    task automatic access(input string tag, input logic rw, input logic [31:0] addr,
                          input logic [1:0] size, input logic [31:0] wdat,
                          input logic [31:0] exp_rd, input logic exp_err, input int hold);
        int   lat;
        logic early;
        int   extra;
        lat   = -1;
        early = 1'b0;
        extra = 0;
        mem_req     = 1'b1;
        mem_en      = 1'b1;
        mem_addr    = addr;
        mem_rd_wr   = rw;
        mem_wr_size = size;
        bus_data_in = wdat;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                // Request already accepted: qualifier drop and field changes must be ignored.
                mem_en      = 1'b0;
                mem_addr    = ~addr;
                mem_rd_wr   = ~rw;
                mem_wr_size = ~size;
                bus_data_in = ~wdat;
            end
            if (mem_data_valid) begin
                lat = i - 1;
                break;
            end
            if (bus_data_oe || bus_data_out != 32'h0) early = 1'b1;
        end
        check({tag, ".latency"}, 32'(lat), 32'd3);
        check({tag, ".pre_oe"}, 32'(early), 32'd0);
        if (lat >= 0) begin
            check({tag, ".oe"},  32'(bus_data_oe), 32'(!rw));
            check({tag, ".dat"}, bus_data_out, rw ? 32'h0 : exp_rd);
            check({tag, ".err"}, 32'(bus_err), 32'(exp_err));
        end
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (mem_data_valid || bus_data_oe) extra++;
            end
            check({tag, ".held_pulses"}, 32'(extra), 32'd0);
            mem_req = 1'b0;
            @(negedge clk);
        end else begin
            mem_req = 1'b0;
            @(negedge clk);
            check_quiet({tag, ".after"});
            @(negedge clk);
        end
    endtask

    initial begin
        reset       = 1'b0;
        mem_req     = 1'b0;
        mem_en      = 1'b0;
        mem_addr    = 32'h0;
        mem_rd_wr   = 1'b0;
        mem_wr_size = 2'b00;
        bus_data_in = 32'h0;
        #2;
        check_quiet("reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Full-word write then read back.
        access("w10",    1'b1, 32'h10, 2'b00, 32'h11223344, 32'h0,        1'b0, 0);
        access("r10",    1'b0, 32'h10, 2'b00, 32'h0,        32'h11223344, 1'b0, 0);

        // Single byte into lane 2.
        access("w12",    1'b1, 32'h12, 2'b01, 32'h000000AB, 32'h0,        1'b0, 0);
        access("r10b",   1'b0, 32'h10, 2'b00, 32'h0,        32'h11AB3344, 1'b0, 0);

        // Held request yields one pulse; a one-cycle gap then lets the next access in.
        access("hold",   1'b0, 32'h10, 2'b00, 32'h0,        32'h11AB3344, 1'b0, 10);
        access("reacc",  1'b0, 32'h10, 2'b00, 32'h0,        32'h11AB3344, 1'b0, 0);

        // Three bytes starting at lane 2: the third byte (CC) falls past lane 3 and is dropped.
        access("w1c",    1'b1, 32'h1C, 2'b00, 32'hFFFFFFFF, 32'h0,        1'b0, 0);
        access("w1e",    1'b1, 32'h1E, 2'b11, 32'h00CCBBAA, 32'h0,        1'b0, 0);
        access("r1c",    1'b0, 32'h1C, 2'b00, 32'h0,        32'hBBAAFFFF, 1'b0, 0);
        // Three bytes starting at lane 1 fit exactly.
        access("w24",    1'b1, 32'h24, 2'b00, 32'hFFFFFFFF, 32'h0,        1'b0, 0);
        access("w25",    1'b1, 32'h25, 2'b11, 32'h00CCBBAA, 32'h0,        1'b0, 0);
        access("r24",    1'b0, 32'h24, 2'b00, 32'h0,        32'hCCBBAAFF, 1'b0, 0);
        // Two bytes into lanes 0..1.
        access("w28",    1'b1, 32'h28, 2'b00, 32'h55667788, 32'h0,        1'b0, 0);
        access("w28h",   1'b1, 32'h28, 2'b10, 32'h0000A1B2, 32'h0,        1'b0, 0);
        access("r28",    1'b0, 32'h28, 2'b00, 32'h0,        32'h5566A1B2, 1'b0, 0);

        // Reset one cycle after a write is accepted: write must be lost.
        access("w20i",   1'b1, 32'h20, 2'b00, 32'h00000000, 32'h0,        1'b0, 0);
        mem_req     = 1'b1;
        mem_en      = 1'b1;
        mem_addr    = 32'h20;
        mem_rd_wr   = 1'b1;
        mem_wr_size = 2'b00;
        bus_data_in = 32'h5A5A5A5A;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_quiet("rst_wr");
        mem_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        access("r20",    1'b0, 32'h20, 2'b00, 32'h0,        32'h00000000, 1'b0, 0);

        // Reset while the completion pulse is up clears outputs with no clock edge.
        mem_req   = 1'b1;
        mem_en    = 1'b1;
        mem_addr  = 32'h10;
        mem_rd_wr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_data_valid) break;
        end
        check("async.vld_seen", 32'(mem_data_valid), 32'd1);
        check("async.dat_seen", bus_data_out, 32'h11AB3344);
        #1;
        reset = 1'b0;
        #1;
        check_quiet("async");
        mem_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        access("r10c",   1'b0, 32'h10, 2'b00, 32'h0,        32'h11AB3344, 1'b0, 0);

        // Address above the array.
        access("w00",    1'b1, 32'h0,  2'b00, 32'hCAFEF00D, 32'h0,        1'b0, 0);
`ifdef MEM_RESP_RANGE_CHECK_EN
        access("rhi",    1'b0, 32'h00010000, 2'b00, 32'h0,  32'hDEADBEEF, 1'b1, 0);
`else
        access("rhi",    1'b0, 32'h00010000, 2'b00, 32'h0,  32'hCAFEF00D, 1'b0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
